soc_reset_sequencer: RTL and testbench
======================================

// Module: soc_reset_sequencer
// PURPOSE
//  Clock/reset sequencer between the board PLL and the picorv32 Wishbone SoC.
//  - Holds the SoC in reset until the PLL is locked and a programmable hold time has elapsed.
//  - Re-enters reset on PLL lock loss or a debounced push-button press.
//  - Provides a slow-clock enable tick, so no divided clock is used as a clock.
//  - Records the last reset cause and a saturating reset count for debug/GPIO.
// PARAMETERS
//  SYNC_STAGES      2     synchroniser depth for pll_locked and btn_reset_n (>=2)
//  HOLD_CYCLES      1024  cycles in HOLD with lock present before SoC reset release (>=1)
//  DEBOUNCE_CYCLES  16    consecutive stable cycles required to accept a button change (>=1)
//  TICK_DIV         512   tick period in clock cycles while running (>=2)
// PORTS
//  clock        in   1  system clock (PLL output)
//  reset_n      in   1  asynchronous active-low reset of this block
//  pll_locked   in   1  PLL lock, asynchronous to clock
//  btn_reset_n  in   1  raw push-button, asynchronous, active-low (0 = pressed)
//  soc_reset    out  1  active-high reset to the SoC, registered
//  tick         out  1  one-cycle enable pulse every TICK_DIV cycles in RUN
//  state_o      out  2  current state encoding (see below)
//  reset_cause  out  2  last reset cause: 00 power-on, 01 lock loss, 10 button
//  reset_count  out  8  count of RUN->reset exits, saturates at 255
// BEHAVIOUR
//  Reset (reset_n=0, takes effect immediately, asynchronously):
//  - state=WAIT_LOCK; soc_reset=1; tick=0; reset_cause=00; reset_count=0; all counters=0.
//  - lock synchroniser flops clear to 0; button synchroniser and debounced value btn_db set to 1 (released).
//  Synchronisation:
//  - lock_s / btn_s are the SYNC_STAGES-flop synchronised inputs.
//  - The FSM uses only lock_s and btn_db, never the raw inputs.
//  Debounce:
//  - A counter increments while btn_s != btn_db and clears whenever they are equal.
//  - btn_db takes btn_s on the edge where the mismatch has persisted DEBOUNCE_CYCLES edges; the counter then clears.
//  States (state_o): WAIT_LOCK=00, HOLD=01, RUN=10, BTN_WAIT=11.
//  - WAIT_LOCK: lock_s=1 -> HOLD with hold_cnt=0.
//  - HOLD: hold_cnt += 1 each cycle.
//      * lock_s=0 -> WAIT_LOCK, cause=01; hold_cnt restarts from 0 on the next HOLD entry.
//      * else btn_db=0 -> BTN_WAIT, cause=10.
//      * else hold_cnt==HOLD_CYCLES-1 -> RUN.
//  - RUN: lock_s=0 -> WAIT_LOCK, cause=01; else btn_db=0 -> BTN_WAIT, cause=10.
//      * Either exit increments reset_count, saturating at 255.
//  - BTN_WAIT: btn_db=1 -> WAIT_LOCK. Lock state is ignored here; WAIT_LOCK rechecks it.
//  - Priority when both events occur in one cycle: lock loss > button > hold expiry.
//  Outputs:
//  - soc_reset = registered (next_state != RUN); it changes on the same edge as state.
//  - Latency from pll_locked rising to soc_reset falling: SYNC_STAGES+1+HOLD_CYCLES edges (1027 by default).
//  - tick_cnt runs 0..TICK_DIV-1 only in RUN and is cleared to 0 in every other state.
//  - tick=1 for exactly the cycle after tick_cnt==TICK_DIV-1; the first tick follows TICK_DIV cycles after RUN entry.
//  - reset_cause is sticky: it changes only on a lock-loss or button transition, never on power-on release.
//  - Counter widths: $clog2 of the respective parameter (minimum 1 bit); no wrap inside HOLD.
// TESTING
//  1 Power-on: reset_n=0 for 3 cycles, pll_locked=1, btn=1 -> soc_reset falls at edge 1027 after release.
//    Then state_o=10, cause=00, count=0.
//  2 Tick: in RUN, count cycles -> tick pulses 1 cycle wide, first 512 cycles after RUN entry, then every 512.
//    tick stays 0 outside RUN.
//  3 Lock loss in RUN: pll_locked->0 -> soc_reset=1 at edge 3, state=00, cause=01, count=1.
//    pll_locked->1 -> soc_reset falls 1027 edges later.
//  4 Button: 10-cycle low glitch -> no change.
//    Held low 40 cycles -> soc_reset=1 at edge 19 after press, state=11, cause=10, count increments.
//    Release -> WAIT_LOCK -> HOLD -> RUN after a full 1024-cycle hold.
//  5 Lock drop at hold_cnt=500, regained 5 cycles later -> state 01->00->01.
//    soc_reset stays 1; a full 1024-cycle hold restarts; count is unchanged.
//  6 reset_n=0 mid-RUN, asynchronous to clock -> soc_reset=1, tick=0, state=00, cause=00, count=0 without a clock edge.
//    Also: lock loss and button press in the same cycle -> cause=01.

Source files
------------

// File: rtl/soc_reset_sequencer_if.sv
// Board-side signals of the SoC reset sequencer: PLL/button inputs, reset, tick and debug status.
interface soc_reset_sequencer_if;
  logic       pll_locked;
  logic       btn_reset_n;
  logic       soc_reset;
  logic       tick;
  logic [1:0] state_o;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  modport master (
    output pll_locked, btn_reset_n,
    input  soc_reset, tick, state_o, reset_cause, reset_count
  );

  modport slave (
    input  pll_locked, btn_reset_n,
    output soc_reset, tick, state_o, reset_cause, reset_count
  );
endinterface

// File: rtl/soc_reset_sequencer.sv
// Holds the SoC in reset until PLL lock plus a hold time, re-enters reset on lock loss or a
// debounced button press, and provides a slow enable tick plus reset cause/count for debug.
module soc_reset_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 512
) (
  input logic                  clock,
  input logic                  reset_n,
  soc_reset_sequencer_if.slave seq
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] StWaitLock = 2'b00;
  localparam logic [1:0] StHold     = 2'b01;
  localparam logic [1:0] StRun      = 2'b10;
  localparam logic [1:0] StBtnWait  = 2'b11;

  localparam logic [1:0] CausePowerOn  = 2'b00;
  localparam logic [1:0] CauseLockLoss = 2'b01;
  localparam logic [1:0] CauseButton   = 2'b10;

  logic [SYNC_STAGES-1:0] lock_sync_q, btn_sync_q;
  logic                   lock_s, btn_s;

  logic           btn_db_q, btn_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  logic [1:0]       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       count_q, count_d;
  logic             soc_reset_q, soc_reset_d;
  logic             tick_q, tick_d;
  logic             run_stay;

  // Button sync resets to released so a power-on never looks like a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], seq.pll_locked};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], seq.btn_reset_n};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    cause_d    = cause_q;
    count_d    = count_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s) state_d = StHold;
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cause_d = CauseLockLoss;
        end else if (!btn_db_q) begin
          state_d = StBtnWait;
          cause_d = CauseButton;
        end else if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cause_d = CauseLockLoss;
        end else if (!btn_db_q) begin
          state_d = StBtnWait;
          cause_d = CauseButton;
        end
        if (state_d != StRun && count_q != 8'hff) count_d = count_q + 8'd1;
      end
      StBtnWait: begin
        if (btn_db_q) state_d = StWaitLock;
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Tick only while RUN persists, so an exit edge never emits a stray pulse.
  assign run_stay = (state_q == StRun) && (state_d == StRun);

  always_comb begin
    tick_cnt_d = '0;
    tick_d     = 1'b0;
    if (run_stay) begin
      if (tick_cnt_q == TickW'(TICK_DIV - 1)) begin
        tick_d = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TickW'(1);
      end
    end
  end

  assign soc_reset_d = (state_d != StRun);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_db_q    <= 1'b1;
      db_cnt_q    <= '0;
      state_q     <= StWaitLock;
      hold_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      cause_q     <= CausePowerOn;
      count_q     <= '0;
      soc_reset_q <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      soc_reset_q <= soc_reset_d;
      tick_q      <= tick_d;
    end
  end

  assign seq.soc_reset   = soc_reset_q;
  assign seq.tick        = tick_q;
  assign seq.state_o     = state_q;
  assign seq.reset_cause = cause_q;
  assign seq.reset_count = count_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer: table of {inputs, cycles, expected outputs} records
// plus hand-written tick, async-reset and simultaneous-event sequences.
module tb_soc_reset_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  soc_reset_sequencer_if seq_if ();

  soc_reset_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .seq     (seq_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       lock;
    logic       btn;
    int         cycles;
    logic       soc;
    logic [1:0] st;
    logic [1:0] cause;
    logic [7:0] cnt;
    logic       tck;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(logic l, logic b, int n, logic s, logic [1:0] st,
                              logic [1:0] c, logic [7:0] cnt, logic t);
    vec_t v;
    v.lock = l; v.btn = b; v.cycles = n; v.soc = s;
    v.st = st; v.cause = c; v.cnt = cnt; v.tck = t;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(string tag, logic s, logic [1:0] st, logic [1:0] c,
                           logic [7:0] cnt, logic t);
    check({tag, " soc_reset"}, 32'(seq_if.soc_reset), 32'(s));
    check({tag, " state"}, 32'(seq_if.state_o), 32'(st));
    check({tag, " cause"}, 32'(seq_if.reset_cause), 32'(c));
    check({tag, " count"}, 32'(seq_if.reset_count), 32'(cnt));
    check({tag, " tick"}, 32'(seq_if.tick), 32'(t));
  endtask

  task automatic run_vecs(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      seq_if.pll_locked  = vecs[i].lock;
      seq_if.btn_reset_n = vecs[i].btn;
      repeat (vecs[i].cycles) step();
      check_all($sformatf("vec%0d", i), vecs[i].soc, vecs[i].st, vecs[i].cause,
                vecs[i].cnt, vecs[i].tck);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int split_a;
    int split_b;

    // Phase A: power-on, lock loss, glitch, button, lock drop mid-hold.
    add(1, 1, 1026, 1, 2'b01, 2'b00, 8'd0, 0);
    add(1, 1, 1,    0, 2'b10, 2'b00, 8'd0, 0);
    split_a = vecs.size();
    add(0, 1, 2,    0, 2'b10, 2'b00, 8'd0, 0);
    add(0, 1, 1,    1, 2'b00, 2'b01, 8'd1, 0);
    add(1, 1, 1026, 1, 2'b01, 2'b01, 8'd1, 0);
    add(1, 1, 1,    0, 2'b10, 2'b01, 8'd1, 0);
    add(1, 0, 10,   0, 2'b10, 2'b01, 8'd1, 0);
    add(1, 1, 30,   0, 2'b10, 2'b01, 8'd1, 0);
    add(1, 0, 18,   0, 2'b10, 2'b01, 8'd1, 0);
    add(1, 0, 1,    1, 2'b11, 2'b10, 8'd2, 0);
    add(1, 0, 21,   1, 2'b11, 2'b10, 8'd2, 0);
    add(1, 1, 18,   1, 2'b11, 2'b10, 8'd2, 0);
    add(1, 1, 1,    1, 2'b00, 2'b10, 8'd2, 0);
    add(1, 1, 1,    1, 2'b01, 2'b10, 8'd2, 0);
    add(1, 1, 1023, 1, 2'b01, 2'b10, 8'd2, 0);
    add(1, 1, 1,    0, 2'b10, 2'b10, 8'd2, 0);
    add(0, 1, 2,    0, 2'b10, 2'b10, 8'd2, 0);
    add(0, 1, 1,    1, 2'b00, 2'b01, 8'd3, 0);
    add(1, 1, 2,    1, 2'b00, 2'b01, 8'd3, 0);
    add(1, 1, 1,    1, 2'b01, 2'b01, 8'd3, 0);
    add(1, 1, 498,  1, 2'b01, 2'b01, 8'd3, 0);
    add(0, 1, 2,    1, 2'b01, 2'b01, 8'd3, 0);
    add(0, 1, 1,    1, 2'b00, 2'b01, 8'd3, 0);
    add(0, 1, 4,    1, 2'b00, 2'b01, 8'd3, 0);
    add(1, 1, 2,    1, 2'b00, 2'b01, 8'd3, 0);
    add(1, 1, 1,    1, 2'b01, 2'b01, 8'd3, 0);
    add(1, 1, 1023, 1, 2'b01, 2'b01, 8'd3, 0);
    add(1, 1, 1,    0, 2'b10, 2'b01, 8'd3, 0);
    split_b = vecs.size();
    // Phase B: after async reset, power-on again then lock loss and button together.
    add(1, 1, 1026, 1, 2'b01, 2'b00, 8'd0, 0);
    add(1, 1, 1,    0, 2'b10, 2'b00, 8'd0, 0);
    add(1, 0, 16,   0, 2'b10, 2'b00, 8'd0, 0);
    add(0, 0, 2,    0, 2'b10, 2'b00, 8'd0, 0);
    add(0, 0, 1,    1, 2'b00, 2'b01, 8'd1, 0);

    seq_if.pll_locked  = 1'b1;
    seq_if.btn_reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_all("por", 1'b1, 2'b00, 2'b00, 8'd0, 1'b0);
    repeat (3) step();
    reset_n = 1'b1;

    run_vecs(0, split_a);

    // Tick: first pulse 512 edges after RUN entry, then every 512, one cycle wide.
    for (int k = 1; k <= 1100; k++) begin
      step();
      check($sformatf("tick k=%0d", k), 32'(seq_if.tick), 32'((k % 512) == 0));
    end

    run_vecs(split_a, split_b);

    // Asynchronous reset mid-RUN, observed between clock edges.
    #3;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 1'b1, 2'b00, 2'b00, 8'd0, 1'b0);
    step();
    step();
    reset_n = 1'b1;

    run_vecs(split_b, vecs.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
